// File: rtl/raycast_pkg.sv
// Shared types and defaults for the raycaster frame scheduling path.
package raycast_pkg;

  // Default frame geometry and pose precision.
  localparam int SCREEN_W     = 320;
  localparam int POSE_W       = 16;
  localparam int MAX_INFLIGHT = 8;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATCH     = 3'd1,
    ISSUE     = 3'd2,
    DRAIN     = 3'd3,
    WAIT_SWAP = 3'd4
  } ray_state_t;

  // Field layout of the packed pose word, most significant field first.
  typedef struct packed {
    logic signed [POSE_W-1:0] pos_x;
    logic signed [POSE_W-1:0] pos_y;
    logic signed [POSE_W-1:0] dir_x;
    logic signed [POSE_W-1:0] dir_y;
    logic signed [POSE_W-1:0] plane_x;
    logic signed [POSE_W-1:0] plane_y;
  } pose_t;

  // Increment an 8-bit counter, sticking at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter bounded to [0, MAX]. An increment arriving while
// already full is dropped and latches a sticky error flag; a decrement at
// zero is dropped silently.
module credit_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         inc_accepted,
  output logic         err
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic full;
  logic empty;
  logic dec_ok;

  assign full         = (count == MAX_C);
  assign empty        = (count == '0);
  assign inc_accepted = inc && !full;
  assign dec_ok       = dec && !empty;

  // Credit balance and sticky over-return flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= MAX_C;
      err   <= 1'b0;
    end else begin
      case ({inc_accepted, dec_ok})
        2'b10:   count <= count + W'(1);
        2'b01:   count <= count - W'(1);
        default: count <= count;
      endcase
      if (inc && full) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_scheduler.sv
// Per-frame ray request scheduler. On each frame start it snapshots the
// camera pose, issues one request per screen column under a credit limit,
// waits for every column to complete, then swaps the frame buffer on the
// last scanned pixel.
//
// Handshake: a request transfers on a cycle where ray_tvalid_out and
// ray_tready_in are both high. Once ray_tvalid_out rises it stays high,
// with ray_col_out / ray_pose_out / ray_tlast_out held constant, until that
// transfer happens.
module ray_scheduler #(
  parameter int SCREEN_W     = raycast_pkg::SCREEN_W,
  parameter int MAX_INFLIGHT = raycast_pkg::MAX_INFLIGHT,
  parameter int POSE_W       = raycast_pkg::POSE_W
) (
  input  logic                        pixel_clk_in,
  input  logic                        rst_in,
  input  logic                        frame_start_in,
  input  logic                        video_last_pixel_in,
  input  logic [6*POSE_W-1:0]         pose_in,
  output logic                        ray_tvalid_out,
  input  logic                        ray_tready_in,
  output logic [$clog2(SCREEN_W)-1:0] ray_col_out,
  output logic [6*POSE_W-1:0]         ray_pose_out,
  output logic                        ray_tlast_out,
  input  logic                        ray_done_in,
  output logic                        swap_out,
  output logic                        busy_out,
  output logic [7:0]                  overrun_count_out,
  output logic                        credit_err_out,
  output logic [2:0]                  fsm_state
);

  import raycast_pkg::*;

  localparam int COL_W  = $clog2(SCREEN_W);
  localparam int DONE_W = $clog2(SCREEN_W + 1);
  localparam int CRED_W = $clog2(MAX_INFLIGHT + 1);

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(SCREEN_W - 1);
  localparam logic [DONE_W-1:0] FRAME_RAYS = DONE_W'(SCREEN_W);

  ray_state_t          state;
  logic [COL_W-1:0]    col;
  logic [DONE_W-1:0]   done_cnt;
  logic [DONE_W-1:0]   done_next;
  logic [6*POSE_W-1:0] pose_q;
  logic                swap_q;
  logic                pending;
  logic [7:0]          overrun;

  logic [CRED_W-1:0]   credits;
  logic                done_ok;
  logic                credit_err;

  logic                xfer;
  logic                count_done;
  logic                pend_take;
  logic                start_extra;

  assign ray_tvalid_out = (state == ISSUE) && (credits != '0);
  assign xfer           = ray_tvalid_out && ray_tready_in;

  // Outstanding-ray budget: spent per transfer, refunded per completion.
  credit_counter #(
    .MAX (MAX_INFLIGHT),
    .W   (CRED_W)
  ) u_credits (
    .clk          (pixel_clk_in),
    .rst          (rst_in),
    .dec          (xfer),
    .inc          (ray_done_in),
    .count        (credits),
    .inc_accepted (done_ok),
    .err          (credit_err)
  );

  // Only completions belonging to the frame in flight advance the tally.
  assign count_done = done_ok && ((state == ISSUE) || (state == DRAIN));
  assign done_next  = done_cnt + DONE_W'(count_done);

  // A queued frame is consumed either straight from IDLE or at the swap.
  assign pend_take   = pending && ((state == IDLE) ||
                       ((state == WAIT_SWAP) && video_last_pixel_in));
  assign start_extra = frame_start_in && (state != IDLE);

  // Main frame sequencing FSM with its column, tally, pose and swap registers.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      col      <= '0;
      done_cnt <= '0;
      pose_q   <= '0;
      swap_q   <= 1'b0;
    end else begin
      swap_q <= 1'b0;
      if (count_done) begin
        done_cnt <= done_next;
      end
      case (state)
        IDLE: begin
          if (frame_start_in || pending) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          pose_q   <= pose_in;
          col      <= '0;
          done_cnt <= '0;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (xfer) begin
            if (col == LAST_COL) begin
              state <= DRAIN;
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (done_next == FRAME_RAYS) begin
            state <= WAIT_SWAP;
          end
        end
        WAIT_SWAP: begin
          if (video_last_pixel_in) begin
            swap_q <= 1'b1;
            state  <= pending ? LATCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-deep frame-start queue and saturating count of starts that overflowed it.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      pending <= 1'b0;
      overrun <= 8'd0;
    end else begin
      if (start_extra) begin
        if (pending && !pend_take) begin
          overrun <= sat_inc8(overrun);
        end else begin
          pending <= 1'b1;
        end
      end else if (pend_take) begin
        pending <= 1'b0;
      end
    end
  end

  assign ray_col_out       = col;
  assign ray_pose_out      = pose_q;
  assign ray_tlast_out     = (state == ISSUE) && (col == LAST_COL);
  assign swap_out          = swap_q;
  assign busy_out          = (state != IDLE);
  assign overrun_count_out = overrun;
  assign credit_err_out    = credit_err;
  assign fsm_state         = state;

endmodule

// File: tb/tb_ray_scheduler.sv
// Randomized bench for ray_scheduler with a small frame (4 columns) and a
// 2-ray in-flight limit so credit exhaustion shows up quickly.
module tb_ray_scheduler;

  import raycast_pkg::*;

  localparam int SW = 4;
  localparam int MI = 2;
  localparam int PW = 16;
  localparam int CW = $clog2(SW);

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in              = 1'b1;
  logic          frame_start_in      = 1'b0;
  logic          video_last_pixel_in = 1'b0;
  logic [6*PW-1:0] pose_in           = '0;
  logic          ray_tready_in       = 1'b0;
  logic          ray_done_in         = 1'b0;

  logic          ray_tvalid_out;
  logic [CW-1:0] ray_col_out;
  logic [6*PW-1:0] ray_pose_out;
  logic          ray_tlast_out;
  logic          swap_out;
  logic          busy_out;
  logic [7:0]    overrun_count_out;
  logic          credit_err_out;
  logic [2:0]    fsm_state;

  ray_scheduler #(
    .SCREEN_W     (SW),
    .MAX_INFLIGHT (MI),
    .POSE_W       (PW)
  ) dut (
    .pixel_clk_in        (clk),
    .rst_in              (rst_in),
    .frame_start_in      (frame_start_in),
    .video_last_pixel_in (video_last_pixel_in),
    .pose_in             (pose_in),
    .ray_tvalid_out      (ray_tvalid_out),
    .ray_tready_in       (ray_tready_in),
    .ray_col_out         (ray_col_out),
    .ray_pose_out        (ray_pose_out),
    .ray_tlast_out       (ray_tlast_out),
    .ray_done_in         (ray_done_in),
    .swap_out            (swap_out),
    .busy_out            (busy_out),
    .overrun_count_out   (overrun_count_out),
    .credit_err_out      (credit_err_out),
    .fsm_state           (fsm_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- scoreboard
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [CW-1:0]   exp_q[$];
  logic [6*PW-1:0] exp_pose = '0;
  int              due_q[$];

  logic auto_done   = 1'b0;
  logic manual_done = 1'b0;

  // Reference model state, owned by the monitor.
  int    outstanding = 0;
  int    xfer_total  = 0;
  int    done_total  = 0;
  int    swap_total  = 0;
  logic  exp_err     = 1'b0;
  logic  stall_prev  = 1'b0;
  logic  xfer_n;
  logic  dn_ok;
  logic [CW-1:0]   exp_col;
  logic [CW-1:0]   prev_col;
  logic [6*PW-1:0] prev_pose;
  logic            prev_tlast;

  // Monitor: samples mid-cycle, checks handshake rules and payloads.
  always @(negedge clk) begin
    if (rst_in) begin
      outstanding = 0;
      exp_err     = 1'b0;
      stall_prev  = 1'b0;
      due_q.delete();
    end else begin
      xfer_n = ray_tvalid_out && ray_tready_in;
      if (stall_prev) begin
        check("hold_tvalid", ray_tvalid_out, 1'b1);
        check("hold_col", ray_col_out, prev_col);
        check("hold_pose", ray_pose_out, prev_pose);
        check("hold_tlast", ray_tlast_out, prev_tlast);
      end
      if (ray_tvalid_out) check("credit_gate", outstanding < MI, 1'b1);
      if (xfer_n) begin
        xfer_total++;
        check("xfer_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_col = exp_q.pop_front();
          check("col", ray_col_out, exp_col);
          check("tlast", ray_tlast_out, exp_col == CW'(SW - 1));
          check("pose", ray_pose_out, exp_pose);
        end
        if (auto_done) due_q.push_back(cyc + 1 + 3);
      end
      dn_ok = ray_done_in && (outstanding > 0);
      if (ray_done_in && !dn_ok) exp_err = 1'b1;
      outstanding = outstanding + int'(xfer_n) - int'(dn_ok);
      if (dn_ok) done_total++;
      if (swap_out) swap_total++;
      stall_prev = ray_tvalid_out && !ray_tready_in;
      prev_col   = ray_col_out;
      prev_pose  = ray_pose_out;
      prev_tlast = ray_tlast_out;
    end
  end

  // Done driver: returns each ray 3 cycles after its transfer, plus manual pulses.
  always @(posedge clk) begin
    logic hit;
    #2;
    hit = 1'b0;
    while (due_q.size() > 0 && due_q[0] < cyc + 1) void'(due_q.pop_front());
    if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
      void'(due_q.pop_front());
      hit = 1'b1;
    end
    ray_done_in = hit | manual_done;
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6*PW-1:0] rand_pose();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic check_reset_outputs();
    check("rst_tvalid", ray_tvalid_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_swap", swap_out, 1'b0);
    check("rst_overrun", overrun_count_out, 8'd0);
    check("rst_credit_err", credit_err_out, 1'b0);
    check("rst_col", ray_col_out, '0);
    check("rst_pose", ray_pose_out, '0);
    check("rst_tlast", ray_tlast_out, 1'b0);
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    exp_q.delete();
    repeat (2) step();
    rst_in = 1'b0;
    check_reset_outputs();
    step();
  endtask

  // Pulse frame_start with a fresh pose; returns in the LATCH cycle.
  task automatic start_frame(input logic [6*PW-1:0] p);
    pose_in  = p;
    exp_pose = p;
    for (int i = 0; i < SW; i++) exp_q.push_back(CW'(i));
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
  endtask

  // Run until all SW rays of the frame have been returned.
  task automatic wait_frame_dones(input int done_base, input logic rand_ready,
                                  input int early_pixel_at);
    int n;
    n = 0;
    while ((done_total - done_base) < SW && n < 400) begin
      if (rand_ready) ray_tready_in = ($urandom_range(0, 1) == 1);
      if (!auto_done) manual_done = (outstanding > 0);
      video_last_pixel_in = (n == early_pixel_at);
      step();
      n++;
    end
    manual_done         = 1'b0;
    video_last_pixel_in = 1'b0;
    check("frame_dones", done_total - done_base, SW);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  task automatic do_swap(input logic expect_relatch);
    int sw_base;
    sw_base = swap_total;
    video_last_pixel_in = 1'b1;
    step();
    video_last_pixel_in = 1'b0;
    check("swap_pulse", swap_out, 1'b1);
    check("busy_after_swap", busy_out, expect_relatch);
    step();
    check("swap_one_cycle", swap_out, 1'b0);
    check("swap_count", swap_total - sw_base, 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int base_x;
    int base_d;
    int base_s;

    apply_reset();

    // Basic frame: full ready, rays returned 3 cycles later, early pixel ignored.
    ray_tready_in = 1'b1;
    auto_done     = 1'b1;
    base_d = done_total;
    base_s = swap_total;
    start_frame(rand_pose());
    check("latency_latch_tvalid", ray_tvalid_out, 1'b0);
    check("latency_latch_busy", busy_out, 1'b1);
    step();
    check("latency_issue_tvalid", ray_tvalid_out, 1'b1);
    check("first_col", ray_col_out, '0);
    pose_in = rand_pose();
    wait_frame_dones(base_d, 1'b0, 3);
    check("no_early_swap", swap_total - base_s, 0);
    do_swap(1'b0);
    check("credit_err_f1", credit_err_out, exp_err);

    // Credit exhaustion with no returns, then one return releases one ray.
    auto_done = 1'b0;
    base_x = xfer_total;
    base_d = done_total;
    start_frame(rand_pose());
    repeat (10) step();
    check("credit_two_xfers", xfer_total - base_x, 2);
    check("credit_stall_tvalid", ray_tvalid_out, 1'b0);
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    repeat (6) step();
    check("credit_one_more", xfer_total - base_x, 3);
    check("credit_stall_again", ray_tvalid_out, 1'b0);
    wait_frame_dones(base_d, 1'b0, -1);
    do_swap(1'b0);

    // Random backpressure over several frames.
    auto_done = 1'b1;
    for (int f = 0; f < 3; f++) begin
      base_d = done_total;
      start_frame(rand_pose());
      step();
      pose_in = rand_pose();
      wait_frame_dones(base_d, 1'b1, -1);
      do_swap(1'b0);
    end
    check("credit_err_rand", credit_err_out, exp_err);

    // Frame starts while busy: pending, overruns, immediate relatch at swap.
    auto_done     = 1'b0;
    ray_tready_in = 1'b1;
    base_d = done_total;
    start_frame(rand_pose());
    for (int i = 0; i < 3; i++) begin
      step();
      frame_start_in = 1'b1;
      step();
      frame_start_in = 1'b0;
    end
    step();
    check("overrun_two", overrun_count_out, 8'd2);
    check("busy_overrun", busy_out, 1'b1);
    frame_start_in = 1'b1;
    repeat (300) step();
    frame_start_in = 1'b0;
    step();
    check("overrun_saturate", overrun_count_out, 8'd255);
    wait_frame_dones(base_d, 1'b0, -1);
    pose_in  = rand_pose();
    exp_pose = pose_in;
    for (int i = 0; i < SW; i++) exp_q.push_back(CW'(i));
    do_swap(1'b1);
    check("relatch_tvalid", ray_tvalid_out, 1'b1);
    check("relatch_state", fsm_state, 3'(ISSUE));
    base_d = done_total;
    wait_frame_dones(base_d, 1'b0, -1);
    do_swap(1'b0);
    check("overrun_hold", overrun_count_out, 8'd255);
    check("credit_err_pending", credit_err_out, exp_err);

    // Spurious done in IDLE: sticky error, credits remain at the limit.
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    step();
    check("spurious_err", credit_err_out, 1'b1);
    check("spurious_model", credit_err_out, exp_err);
    check("spurious_idle", busy_out, 1'b0);
    base_x = xfer_total;
    start_frame(rand_pose());
    repeat (10) step();
    check("spurious_credits", xfer_total - base_x, MI);
    apply_reset();

    // Reset in ISSUE with a request pending: frame abandoned, no swap.
    ray_tready_in = 1'b0;
    start_frame(rand_pose());
    step();
    check("issue_before_rst", ray_tvalid_out, 1'b1);
    rst_in = 1'b1;
    exp_q.delete();
    step();
    check("rst_mid_busy", busy_out, 1'b0);
    check("rst_mid_tvalid", ray_tvalid_out, 1'b0);
    rst_in = 1'b0;
    base_s = swap_total;
    for (int i = 0; i < 20; i++) begin
      video_last_pixel_in = (i % 5 == 2);
      step();
    end
    video_last_pixel_in = 1'b0;
    check("rst_no_swap", swap_total - base_s, 0);

    // Recovery frame after the abandoned one.
    auto_done     = 1'b1;
    ray_tready_in = 1'b1;
    base_d = done_total;
    start_frame(rand_pose());
    step();
    wait_frame_dones(base_d, 1'b0, -1);
    do_swap(1'b0);
    check("credit_err_final", credit_err_out, exp_err);

    // ---------------------------------------------------------------- report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
